// File: rtl/map_render.sv
// Pixel colour generator for a bordered, optionally gridded playfield with a
// frame-synchronous mode register and game-over flash. Fixed 2-cycle latency.
module map_render #(
  parameter int SCREEN_WIDTH     = 640,
  parameter int SCREEN_HEIGHT    = 480,
  parameter int BORDER_THICKNESS = 20,
  parameter int CELL_LOG2        = 4,
  parameter int FLASH_FRAMES     = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic        pix_valid,
  input  logic        frame_start,
  input  logic [1:0]  mode,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        rgb_valid,
  output logic        flash_phase
);

  typedef enum logic [1:0] {
    REG_OFF,
    REG_BORDER,
    REG_GRID,
    REG_PLAIN
  } region_t;

  typedef enum logic [1:0] {
    MODE_NORMAL,
    MODE_GRID,
    MODE_FLASH,
    MODE_BLANK
  } mode_t;

  localparam logic [11:0] W      = 12'(SCREEN_WIDTH);
  localparam logic [11:0] H      = 12'(SCREEN_HEIGHT);
  localparam logic [11:0] B      = 12'(BORDER_THICKNESS);
  localparam logic [11:0] W_IN   = 12'(SCREEN_WIDTH - BORDER_THICKNESS);
  localparam logic [11:0] H_IN   = 12'(SCREEN_HEIGHT - BORDER_THICKNESS);
  localparam logic [7:0]  F_LAST = 8'(FLASH_FRAMES - 1);

  logic [11:0] dx, dy;
  region_t     region_d, region_q;
  logic        valid_q;
  mode_t       active_mode;
  logic [7:0]  flash_cnt;
  logic [23:0] rgb_d;

  // Stage 1 classification; grid offsets wrap in 12 bits by design.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    region_d = REG_PLAIN;
    dx = x - B;
    dy = y - B;
    if (x >= W || y >= H)
      region_d = REG_OFF;
    else if (x < B || x >= W_IN || y < B || y >= H_IN)
      region_d = REG_BORDER;
    else if (dx[CELL_LOG2-1:0] == '0 || dy[CELL_LOG2-1:0] == '0)
      region_d = REG_GRID;
  end

  // NOTE: state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      region_q <= REG_OFF;
      valid_q  <= 1'b0;
    end else begin
      region_q <= region_d;
      valid_q  <= pix_valid;
    end
  end

  // Mode and flash state move only on frame_start; the mode register is loaded
  // at the same edge as the pixel, so stage 2 sees the mode that pixel belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_mode <= MODE_NORMAL;
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (frame_start) begin
      active_mode <= mode_t'(mode);
      if (mode_t'(mode) == MODE_FLASH && active_mode == MODE_FLASH) begin
        if (flash_cnt == F_LAST) begin
          flash_cnt   <= '0;
          flash_phase <= ~flash_phase;
        end else begin
          flash_cnt <= flash_cnt + 8'd1;
        end
      end else begin
        flash_cnt   <= '0;
        flash_phase <= 1'b0;
      end
    end
  end

  always_comb begin
    rgb_d = 24'h000000;
    if (valid_q && region_q != REG_OFF) begin
      unique case (active_mode)
        MODE_NORMAL: rgb_d = (region_q == REG_BORDER) ? 24'hFF0000 : 24'h808080;
        MODE_GRID: begin
          if (region_q == REG_BORDER)    rgb_d = 24'hFF0000;
          else if (region_q == REG_GRID) rgb_d = 24'h404040;
          else                           rgb_d = 24'h808080;
        end
        MODE_FLASH: begin
          if (region_q == REG_BORDER) rgb_d = flash_phase ? 24'hFFFFFF : 24'hFF0000;
          else                        rgb_d = 24'h202020;
        end
        MODE_BLANK: rgb_d = 24'h000000;
      endcase
    end
  end

  // NOTE: both pipeline stages reset so no in-flight pixel survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_valid <= 1'b0;
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
    end else begin
      rgb_valid               <= valid_q;
      {vga_r, vga_g, vga_b}   <= rgb_d;
    end
  end

endmodule

// File: tb/tb_map_render.sv
// Self-checking bench for map_render: directed scenarios plus random traffic
// compared against a frame-level reference model.
module tb_map_render;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int B  = 20;
  localparam int CL = 4;
  localparam int FF = 3;

  logic        clk;
  logic        rst_n;
  logic [11:0] x, y;
  logic        pix_valid, frame_start;
  logic [1:0]  mode;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        rgb_valid, flash_phase;

  map_render #(
    .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .BORDER_THICKNESS(B),
    .CELL_LOG2(CL), .FLASH_FRAMES(FF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .pix_valid(pix_valid),
    .frame_start(frame_start), .mode(mode), .vga_r(vga_r), .vga_g(vga_g),
    .vga_b(vga_b), .rgb_valid(rgb_valid), .flash_phase(flash_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: frame-level mode/flash plus the one pixel in flight.
  int          m_mode = 0;
  int          m_cnt  = 0;
  bit          m_phase = 1'b0;
  logic [24:0] m_prev = '0;

  function automatic logic [24:0] expect_pix(int px, int py, bit pv, int md, bit ph);
    bit border, grid;
    if (!pv) return 25'h0;
    if (px >= W || py >= H) return {1'b1, 24'h000000};
    border = (px < B) || (px >= W - B) || (py < B) || (py >= H - B);
    grid   = (((px - B) & 4095) % (1 << CL) == 0) || (((py - B) & 4095) % (1 << CL) == 0);
    case (md)
      3: return {1'b1, 24'h000000};
      2: return border ? (ph ? {1'b1, 24'hFFFFFF} : {1'b1, 24'hFF0000}) : {1'b1, 24'h202020};
      1: return border ? {1'b1, 24'hFF0000} : (grid ? {1'b1, 24'h404040} : {1'b1, 24'h808080});
      default: return border ? {1'b1, 24'hFF0000} : {1'b1, 24'h808080};
    endcase
  endfunction

  task automatic step(input int px, input int py, input bit pv, input bit fs, input int md);
    int em;
    logic [24:0] cur;
    x = 12'(px);
    y = 12'(py);
    pix_valid   = pv;
    frame_start = fs;
    mode        = 2'(md);
    @(posedge clk);
    em = fs ? md : m_mode;
    if (fs) begin
      if (md == 2 && m_mode == 2) begin
        if (m_cnt == FF - 1) begin
          m_cnt = 0;
          m_phase = ~m_phase;
        end else begin
          m_cnt++;
        end
      end else begin
        m_cnt = 0;
        m_phase = 1'b0;
      end
    end
    m_mode = em;
    cur = expect_pix(px, py, pv, em, m_phase);
    #1;
    check("rgb_valid", 32'(rgb_valid), 32'(m_prev[24]));
    check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(m_prev[23:0]));
    check("flash_phase", 32'(flash_phase), 32'(m_phase));
    m_prev = cur;
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from any clock edge.
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(rgb_valid), 32'd0);
    check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    check("rst_flash", 32'(flash_phase), 32'd0);
    m_mode = 0;
    m_cnt = 0;
    m_phase = 1'b0;
    m_prev = '0;
    #2 rst_n = 1'b1;
  endtask

  int exp_ph[7] = '{0, 0, 0, 1, 1, 1, 0};

  initial begin
    int px, py, md;
    bit pv, fs;
    rst_n = 1'b0;
    x = '0; y = '0; pix_valid = 1'b0; frame_start = 1'b0; mode = 2'd0;
    #1;
    check("reset_valid", 32'(rgb_valid), 32'd0);
    check("reset_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    check("reset_flash", 32'(flash_phase), 32'd0);
    #12 rst_n = 1'b1;

    // Mode 0 region colours.
    step(0, 0, 0, 1, 0);
    step(19, 100, 1, 0, 0);
    step(20, 100, 1, 0, 0);
    check("m0_border_left", 32'({vga_r, vga_g, vga_b}), 32'hFF0000);
    step(620, 240, 1, 0, 0);
    check("m0_interior", 32'({vga_r, vga_g, vga_b}), 32'h808080);
    step(640, 0, 1, 0, 0);
    check("m0_border_right", 32'({vga_r, vga_g, vga_b}), 32'hFF0000);
    step(0, 0, 0, 0, 0);
    check("m0_off", 32'({vga_r, vga_g, vga_b}), 32'h000000);
    check("m0_off_valid", 32'(rgb_valid), 32'd1);
    step(0, 0, 0, 0, 0);
    check("idle_valid", 32'(rgb_valid), 32'd0);

    // Mode 1 grid lines.
    step(0, 0, 0, 1, 1);
    step(36, 50, 1, 0, 1);
    step(37, 51, 1, 0, 1);
    check("m1_grid_x", 32'({vga_r, vga_g, vga_b}), 32'h404040);
    step(100, 36, 1, 0, 1);
    check("m1_plain", 32'({vga_r, vga_g, vga_b}), 32'h808080);
    step(0, 0, 0, 0, 1);
    check("m1_grid_y", 32'({vga_r, vga_g, vga_b}), 32'h404040);

    // Mode changed mid-frame is ignored until frame_start; that cycle uses it.
    step(36, 50, 1, 0, 0);
    step(36, 50, 1, 1, 0);
    check("midframe_hold", 32'({vga_r, vga_g, vga_b}), 32'h404040);
    step(0, 0, 0, 0, 0);
    check("fs_new_mode", 32'({vga_r, vga_g, vga_b}), 32'h808080);

    // Seven mode-2 frames with FLASH_FRAMES=3.
    for (int f = 0; f < 7; f++) begin
      step(0, 0, 0, 1, 2);
      check($sformatf("flash_f%0d", f), 32'(flash_phase), 32'(exp_ph[f]));
      step(5, 5, 1, 0, 2);
      step(300, 300, 1, 0, 2);
      check($sformatf("flash_border_f%0d", f), 32'({vga_r, vga_g, vga_b}),
            exp_ph[f] != 0 ? 32'hFFFFFF : 32'hFF0000);
      step(0, 0, 0, 0, 2);
      check($sformatf("flash_int_f%0d", f), 32'({vga_r, vga_g, vga_b}), 32'h202020);
    end

    // Reset mid-stream with continuous pix_valid.
    step(0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(100 + i, 200, 1, 0, 0);
    reset_pulse();
    step(5, 200, 1, 0, 0);
    check("post_rst_first", 32'(rgb_valid), 32'd0);
    step(100, 200, 1, 0, 0);
    check("post_rst_second", 32'(rgb_valid), 32'd1);
    check("post_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'hFF0000);

    // Random traffic with occasional frame starts, mode changes and resets.
    md = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) md = int'($urandom_range(3));
      fs = ($urandom_range(15) == 0);
      pv = ($urandom_range(3) != 0);
      px = int'($urandom_range(700));
      py = int'($urandom_range(520));
      if ($urandom_range(3) == 0) px = B + 16 * int'($urandom_range(40));
      if ($urandom_range(3) == 0) py = B + 16 * int'($urandom_range(30));
      step(px, py, pv, fs, md);
      if ($urandom_range(799) == 0) reset_pulse();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/map_render.md
MAP_RENDER -- requirements
Module: map_render

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 640, visible pixel columns.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 480, visible pixel rows.
REQ-003 SHALL have parameter BORDER_THICKNESS, default 20, border width in pixels on every edge.
REQ-004 SHALL have parameter CELL_LOG2, default 4, log2 of the grid cell size in pixels.
REQ-005 SHALL have parameter FLASH_FRAMES, default 15, frames per flash half-period (legal range 1..255).
REQ-006 SHALL have port clk, input, 1 bit, single clock; all state updates on rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit; one clock, reset asynchronous and active-low.
REQ-008 SHALL have port x, input, 12 bits, pixel column.
REQ-009 SHALL have port y, input, 12 bits, pixel row.
REQ-010 SHALL have port pix_valid, input, 1 bit, x/y valid this cycle.
REQ-011 SHALL have port frame_start, input, 1 bit, one-cycle pulse at the start of each frame.
REQ-012 SHALL have port mode, input, 2 bits: 0 = normal, 1 = grid, 2 = game-over flash, 3 = blank.
REQ-013 SHALL have ports vga_r, vga_g and vga_b, outputs, 8 bits each, pixel colour.
REQ-014 SHALL have port rgb_valid, output, 1 bit, vga_* valid.
REQ-015 SHALL have port flash_phase, output, 1 bit, current flash half-period.

Function
REQ-016 SHALL be a 2-stage pipeline: x/y/pix_valid sampled in cycle N -> vga_*/rgb_valid in cycle N+2, fixed latency, no stalls.
REQ-017 Stage 1 SHALL register the region class and pix_valid; stage 2 SHALL register the colour.
REQ-018 Region "off" SHALL be x >= SCREEN_WIDTH or y >= SCREEN_HEIGHT; off takes priority over all other regions.
REQ-019 Region "border" SHALL be x < BORDER_THICKNESS, x >= SCREEN_WIDTH-BORDER_THICKNESS, y < BORDER_THICKNESS, or y >= SCREEN_HEIGHT-BORDER_THICKNESS; all other on-screen pixels are "interior".
REQ-020 An interior pixel SHALL be a grid line when bits [CELL_LOG2-1:0] of (x-BORDER_THICKNESS) or of (y-BORDER_THICKNESS) are all zero, using 12-bit subtraction.
REQ-021 active_mode SHALL load from mode only in a cycle where frame_start=1; at all other times it holds.
REQ-022 A pixel sampled in the same cycle as frame_start SHALL use the incoming mode value, not the old active_mode.
REQ-023 Colours SHALL be: off -> 0/0/0; border -> 255/0/0; interior -> 128/128/128.
REQ-024 Mode 1 SHALL change interior grid-line pixels to 64/64/64; all other pixels keep the colours of REQ-023.
REQ-025 Mode 2 SHALL colour border pixels 255/255/255 when flash_phase=1 and 255/0/0 when flash_phase=0, and SHALL colour interior pixels 32/32/32.
REQ-026 Mode 3 SHALL output 0/0/0 for every pixel.
REQ-027 rgb_valid SHALL equal pix_valid delayed by 2 cycles; vga_* SHALL be 0/0/0 whenever rgb_valid=0.
REQ-028 Flash counter: 8-bit flash_cnt, updated only on a cycle where frame_start=1.
REQ-029 On frame_start with mode=2 and active_mode!=2, flash_cnt SHALL be set to 0 and flash_phase to 0 (entry).
REQ-030 On frame_start with mode=2 and active_mode=2, flash_cnt SHALL increment; at FLASH_FRAMES-1 it SHALL wrap to 0 and toggle flash_phase.
REQ-031 On frame_start with mode!=2, flash_cnt SHALL be set to 0 and flash_phase to 0.
REQ-032 flash_phase SHALL be a direct register output, valid the cycle after the frame_start that updated it.

Reset
REQ-033 Asserting rst_n=0 SHALL immediately clear active_mode to 0, flash_cnt to 0, flash_phase to 0, both pipeline stages, rgb_valid to 0 and vga_* to 0, with no clock edge required.
REQ-034 After rst_n deasserts, the first valid output SHALL appear 2 cycles after the first pix_valid=1 sample.
REQ-035 Reset mid-frame SHALL discard in-flight pixels; no stale rgb_valid SHALL be produced after release.

Verification
REQ-036 Mode 0, pixels (19,100),(20,100),(620,240),(640,0) -> 2 cycles later 255/0/0, 128/128/128, 255/0/0, 0/0/0.
REQ-037 Mode 1 latched at frame_start, pixels (36,50),(37,51),(100,36) -> 64/64/64, 128/128/128, 64/64/64.
REQ-038 Mode 2 with FLASH_FRAMES=3 held for 7 frames -> flash_phase 0,0,0,1,1,1,0 after each frame_start; border alternates red/white to match.
REQ-039 Mode input changed mid-frame without frame_start -> colours unchanged until the next frame_start; a pixel in the frame_start cycle uses the new mode.
REQ-040 Continuous pix_valid with rst_n pulsed low mid-stream -> rgb_valid and vga_* at 0 immediately; after release, output resumes exactly 2 cycles after pix_valid.
